serial_tx_mod: RTL and testbench



---
 rtl/serial_tx_mod.sv | 142 ++++++++++++++
 tb/tb_serial_tx_mod.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_tx_mod.sv
// Serial-link transmitter: frames one parallel word as start bit, data bits
// LSB first, optional even parity, then stop bit. Each bit lasts OVERSAMPLE
// clocks, and a strobe marks the middle of every bit.
//
// Ports:
//   sc_clk_ctrl  in   link clock, rising edge
//   reset        in   synchronous, active-high reset
//   tx_data      in   word to send, captured at accept
//   tx_start     in   send request, accepted whenever tx_busy=0
//   tx_busy      out  high from the accept edge through the last stop-bit cycle
//   tx_done      out  one-cycle pulse right after the stop bit
//   S_data_out   out  serial line, idles high
//   sample_phase out  one-clock strobe at bit-counter value OVERSAMPLE/2
module serial_tx_mod #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned PARITY_EN  = 0
) (
  input  logic                 sc_clk_ctrl,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 S_data_out,
  output logic                 sample_phase
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 phase_q, phase_d;
  logic                 bit_end;

  // Next-state logic; outputs are derived from the next state so the
  // registered line already reflects the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (tx_start) begin
          shift_d = tx_data;
          par_d   = ^tx_data;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase

    busy_d  = (state_d != S_IDLE);
    phase_d = (state_d != S_IDLE) && (cnt_d == CNT_MID);
  end

  // State and output registers
  always_ff @(posedge sc_clk_ctrl) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      phase_q <= phase_d;
    end
  end

  assign S_data_out   = line_q;
  assign tx_busy      = busy_q;
  assign tx_done      = done_q;
  assign sample_phase = phase_q;

endmodule

// File: tb/tb_serial_tx_mod.sv
// Bench for serial_tx_mod: two instances (no parity / even parity) share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_serial_tx_mod;

  localparam int OS = 8;
  localparam int DB = 8;

  logic          clk;
  logic          reset;
  logic [DB-1:0] tx_data;
  logic          tx_start;
  logic [1:0]    busy, done, line, phase;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_tx_mod #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(0)) u_dut0 (
    .sc_clk_ctrl(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(busy[0]), .tx_done(done[0]), .S_data_out(line[0]),
    .sample_phase(phase[0]));

  serial_tx_mod #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(1)) u_dut1 (
    .sc_clk_ctrl(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(busy[1]), .tx_done(done[1]), .S_data_out(line[1]),
    .sample_phase(phase[1]));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: a frame is a list of bits, each held OS clocks.
  bit m_bits [2][0:DB+2];
  int m_k    [2];
  int m_len  [2];
  bit m_busy [2];
  bit m_done [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] = 0;
        m_done[i] = 0;
      end else if (!m_busy[i]) begin
        m_done[i] = 0;
        if (tx_start) begin
          int nb;
          nb = 0;
          m_bits[i][nb++] = 1'b0;
          for (int b = 0; b < DB; b++) m_bits[i][nb++] = tx_data[b];
          if (i == 1) m_bits[i][nb++] = ^tx_data;
          m_bits[i][nb++] = 1'b1;
          m_len[i]  = nb * OS;
          m_k[i]    = 0;
          m_busy[i] = 1;
        end
      end else if (m_k[i] == m_len[i] - 1) begin
        m_busy[i] = 0;
        m_done[i] = 1;
      end else begin
        m_k[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (done[0] === 1'b1) done_cnt0++;
    if (done[1] === 1'b1) done_cnt1++;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit e_line, e_phase;
        e_line  = m_busy[i] ? m_bits[i][m_k[i] / OS] : 1'b1;
        e_phase = m_busy[i] && ((m_k[i] % OS) == OS / 2);
        check($sformatf("line%0d", i),  int'(line[i]),  int'(e_line));
        check($sformatf("busy%0d", i),  int'(busy[i]),  int'(m_busy[i]));
        check($sformatf("done%0d", i),  int'(done[i]),  int'(m_done[i]));
        check($sformatf("phase%0d", i), int'(phase[i]), int'(e_phase));
      end
    end
  end

  task automatic send(input logic [DB-1:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  initial begin
    int c0, c1;
    bit seen;
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1;
    repeat (20) @(negedge clk);

    // Plain frame and parity frame
    send(8'hA5);
    repeat (95) @(negedge clk);
    send(8'h07);
    repeat (95) @(negedge clk);

    // Back-to-back: re-request in the tx_done cycle
    c0 = done_cnt0;
    send(8'h01);
    seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      if (done[0] === 1'b1) seen = 1;
      else @(negedge clk);
    end
    check("b2b_done_seen", int'(seen), 1);
    send(8'hFF);
    repeat (100) @(negedge clk);
    check("b2b_done_count", done_cnt0 - c0, 2);

    // Mid-frame request and data change are ignored
    c0 = done_cnt0;
    send(8'h3C);
    repeat (29) @(negedge clk);
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (100) @(negedge clk);
    check("ignore_done_count", done_cnt0 - c0, 1);

    // Reset mid-frame, then a clean frame
    c0 = done_cnt0;
    c1 = done_cnt1;
    send(8'h5A);
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_line", int'(line[0]), 1);
    check("rst_busy", int'(busy[0]), 0);
    repeat (20) @(negedge clk);
    check("rst_no_done0", done_cnt0 - c0, 0);
    check("rst_no_done1", done_cnt1 - c1, 0);
    send(8'h96);
    repeat (95) @(negedge clk);

    // Random traffic with occasional resets and simultaneous reset+start
    for (int t = 0; t < 3000; t++) begin
      tx_data  = DB'($urandom);
      tx_start = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    tx_start = 1'b0;
    reset    = 1'b0;
    repeat (100) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
